// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong ball datapath: coordinate widths,
// default geometry and the ball FSM state encoding.
package pong_pkg;

  localparam int COORD_W = 10;
  localparam int CALC_W  = COORD_W + 1;
  localparam int SCORE_W = 4;

  localparam int SCREEN_W_DEF  = 640;
  localparam int SCREEN_H_DEF  = 480;
  localparam int BALL_SIZE_DEF = 10;
  localparam int PADDLE_W_DEF  = 30;
  localparam int PADDLE_H_DEF  = 200;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CALC_W-1:0]  calc_t;

  typedef enum logic [1:0] {
    ST_SERVE     = 2'd0,
    ST_PLAY      = 2'd1,
    ST_SCORED    = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_e;

  // Zero-extend a screen coordinate so sums and differences never wrap.
  function automatic calc_t widen(input coord_t c);
    return {1'b0, c};
  endfunction

endpackage

// File: rtl/paddle_hit.sv
// Combinational paddle collision test: vertical overlap plus a horizontal
// crossing check against the paddle face nearest the centre of the screen.
module paddle_hit
  import pong_pkg::*;
#(
  parameter bit RIGHT_SIDE = 1'b0,
  parameter int BALL_SIZE  = BALL_SIZE_DEF,
  parameter int PADDLE_W   = PADDLE_W_DEF,
  parameter int PADDLE_H   = PADDLE_H_DEF
) (
  input  logic [COORD_W-1:0] ball_x_i,
  input  logic [COORD_W-1:0] ball_y_i,
  input  logic [COORD_W-1:0] paddle_x_i,
  input  logic [COORD_W-1:0] paddle_y_i,
  input  logic [CALC_W-1:0]  step_i,
  input  logic               toward_i,
  output logic               hit_o
);

  localparam calc_t BS = calc_t'(BALL_SIZE);
  localparam calc_t PW = calc_t'(PADDLE_W);
  localparam calc_t PH = calc_t'(PADDLE_H);

  calc_t bx, by, px, py;
  logic  overlap, crossing;

  assign bx = widen(ball_x_i);
  assign by = widen(ball_y_i);
  assign px = widen(paddle_x_i);
  assign py = widen(paddle_y_i);

  assign overlap = (by + BS > py) && (by < py + PH);

  // Left crossing is written as bx <= face+step so nothing is subtracted.
  generate
    if (RIGHT_SIDE) begin : g_right
      assign crossing = (bx + BS <= px) && (bx + BS + step_i >= px);
    end else begin : g_left
      assign crossing = (bx >= px + PW) && (bx <= px + PW + step_i);
    end
  endgenerate

  assign hit_o = toward_i && overlap && crossing;

endmodule

// File: rtl/pong_ball.sv
// Ball physics and scoring: serve delay, wall/paddle bounces, misses, scores
// and game-over. Define PONG_BALL_SPEEDUP_EN to grow the X step per rally hit.
module pong_ball
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int BALL_SIZE   = BALL_SIZE_DEF,
  parameter int PADDLE_W    = PADDLE_W_DEF,
  parameter int PADDLE_H    = PADDLE_H_DEF,
  parameter int SPEED_X     = 4,
  parameter int SPEED_Y     = 2,
  parameter int SERVE_TICKS = 60,
  parameter int WIN_SCORE   = 7
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               game_tick,
  input  logic               restart,
  input  logic [COORD_W-1:0] p1_x,
  input  logic [COORD_W-1:0] p1_y,
  input  logic [COORD_W-1:0] p2_x,
  input  logic [COORD_W-1:0] p2_y,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               point,
  output logic               game_over
);

  localparam int     CNT_W = $clog2(SERVE_TICKS + 1);
  localparam calc_t  SW    = calc_t'(SCREEN_W);
  localparam calc_t  SH    = calc_t'(SCREEN_H);
  localparam calc_t  BS    = calc_t'(BALL_SIZE);
  localparam calc_t  PW    = calc_t'(PADDLE_W);
  localparam calc_t  SPY   = calc_t'(SPEED_Y);
  localparam coord_t CX    = coord_t'((SCREEN_W - BALL_SIZE) / 2);
  localparam coord_t CY    = coord_t'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE = SCORE_W'(1);

  state_e             state_q;
  coord_t             ball_x_q, ball_y_q;
  logic               dx_q, dy_q;
  logic [SCORE_W-1:0] score1_q, score2_q;
  logic               point_q, game_over_q, scorer_p1_q;
  logic [CNT_W-1:0]   serve_cnt_q;

  calc_t  step_x, bx, by;
  logic   hit_l, hit_r, miss_l, miss_r;
  coord_t play_x_d, play_y_d;
  logic   play_dx_d, play_dy_d;

`ifdef PONG_BALL_SPEEDUP_EN
  logic [2:0] rally_q;
  assign step_x = calc_t'(SPEED_X) + calc_t'(rally_q);
`else
  assign step_x = calc_t'(SPEED_X);
`endif

  assign bx = widen(ball_x_q);
  assign by = widen(ball_y_q);

  paddle_hit #(
    .RIGHT_SIDE(1'b0), .BALL_SIZE(BALL_SIZE), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H)
  ) u_hit_p1 (
    .ball_x_i(ball_x_q), .ball_y_i(ball_y_q), .paddle_x_i(p1_x), .paddle_y_i(p1_y),
    .step_i(step_x), .toward_i(~dx_q), .hit_o(hit_l)
  );

  paddle_hit #(
    .RIGHT_SIDE(1'b1), .BALL_SIZE(BALL_SIZE), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H)
  ) u_hit_p2 (
    .ball_x_i(ball_x_q), .ball_y_i(ball_y_q), .paddle_x_i(p2_x), .paddle_y_i(p2_y),
    .step_i(step_x), .toward_i(dx_q), .hit_o(hit_r)
  );

  // One PLAY step; X and Y are resolved independently from pre-move values.
  always_comb begin
    play_y_d  = ball_y_q;
    play_dy_d = dy_q;
    if (!dy_q && by < SPY) begin
      play_y_d  = '0;
      play_dy_d = 1'b1;
    end else if (dy_q && by + BS + SPY >= SH) begin
      play_y_d  = coord_t'(SH - BS);
      play_dy_d = 1'b0;
    end else if (dy_q) begin
      play_y_d = coord_t'(by + SPY);
    end else begin
      play_y_d = coord_t'(by - SPY);
    end

    play_x_d  = ball_x_q;
    play_dx_d = dx_q;
    miss_l    = 1'b0;
    miss_r    = 1'b0;
    if (hit_l) begin
      play_x_d  = coord_t'(widen(p1_x) + PW + calc_t'(1));
      play_dx_d = 1'b1;
    end else if (hit_r) begin
      play_x_d  = coord_t'(widen(p2_x) - BS - calc_t'(1));
      play_dx_d = 1'b0;
    end else if (!dx_q && bx < step_x) begin
      miss_l = 1'b1;
    end else if (dx_q && bx + BS + step_x >= SW) begin
      miss_r = 1'b1;
    end else if (dx_q) begin
      play_x_d = coord_t'(bx + step_x);
    end else begin
      play_x_d = coord_t'(bx - step_x);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_SERVE;
      ball_x_q    <= CX;
      ball_y_q    <= CY;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      score1_q    <= '0;
      score2_q    <= '0;
      point_q     <= 1'b0;
      game_over_q <= 1'b0;
      scorer_p1_q <= 1'b0;
      serve_cnt_q <= '0;
`ifdef PONG_BALL_SPEEDUP_EN
      rally_q     <= '0;
`endif
    end else begin
      point_q <= 1'b0;
      case (state_q)
        ST_SERVE: begin
          if (game_tick) begin
            if (serve_cnt_q == CNT_W'(SERVE_TICKS - 1)) begin
              serve_cnt_q <= '0;
              state_q     <= ST_PLAY;
            end else begin
              serve_cnt_q <= serve_cnt_q + 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (game_tick) begin
            ball_y_q <= play_y_d;
            dy_q     <= play_dy_d;
            if (miss_l || miss_r) begin
              scorer_p1_q <= miss_r;
              state_q     <= ST_SCORED;
            end else begin
              ball_x_q <= play_x_d;
              dx_q     <= play_dx_d;
            end
`ifdef PONG_BALL_SPEEDUP_EN
            if ((hit_l || hit_r) && rally_q != 3'd7)
              rally_q <= rally_q + 3'd1;
`endif
          end
        end
        ST_SCORED: begin
          point_q     <= 1'b1;
          ball_x_q    <= CX;
          ball_y_q    <= CY;
          serve_cnt_q <= '0;
`ifdef PONG_BALL_SPEEDUP_EN
          rally_q     <= '0;
`endif
          // Next serve heads toward whoever just conceded.
          if (scorer_p1_q) begin
            score1_q <= score1_q + ONE;
            dx_q     <= 1'b1;
            if (score1_q + ONE == WIN) begin
              state_q     <= ST_GAME_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q <= ST_SERVE;
            end
          end else begin
            score2_q <= score2_q + ONE;
            dx_q     <= 1'b0;
            if (score2_q + ONE == WIN) begin
              state_q     <= ST_GAME_OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q <= ST_SERVE;
            end
          end
        end
        ST_GAME_OVER: begin
          if (restart) begin
            score1_q    <= '0;
            score2_q    <= '0;
            dx_q        <= 1'b1;
            serve_cnt_q <= '0;
            game_over_q <= 1'b0;
            state_q     <= ST_SERVE;
          end
        end
      endcase
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign score_p1  = score1_q;
  assign score_p2  = score2_q;
  assign point     = point_q;
  assign game_over = game_over_q;

endmodule

// File: doc/pong_ball.md
Name: pong_ball

Overview:
- Ball-physics and scoring stage of the Pong datapath.
- Sits downstream of the game-tick counter and the two paddle blocks, and upstream of the pixel renderer.
- On each game tick it advances the ball and handles wall and paddle bounces, misses, scoring, serve delay and game-over.
- Outputs the ball's top-left coordinates for drawing, plus per-player scores.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
BALL_SIZE, 10, ball edge length (square)
PADDLE_W, 30, paddle width
PADDLE_H, 200, paddle height
SPEED_X, 4, horizontal step per tick
SPEED_Y, 2, vertical step per tick
SERVE_TICKS, 60, ticks the ball rests at centre before moving
WIN_SCORE, 7, score that ends the game (1..15)

Ports:
clk  input  1  system clock; the only clock
rst_b  input  1  asynchronous active-low reset
game_tick  input  1  one-cycle enable pulse from the game-tick counter
restart  input  1  one-cycle pulse; leaves GAME_OVER
p1_x, p1_y  input  10  left paddle top-left position
p2_x, p2_y  input  10  right paddle top-left position
ball_x, ball_y  output  10  ball top-left position, registered
score_p1, score_p2  output  4  scores, registered
point  output  1  one-cycle pulse when a point is awarded
game_over  output  1  high while in GAME_OVER

Behaviour:
- Interface: one clock `clk`; reset `rst_b` is asynchronous and active-low.
- Reset values:
  - ball_x=(SCREEN_W-BALL_SIZE)/2=315, ball_y=(SCREEN_H-BALL_SIZE)/2=235.
  - Scores 0, point=0, game_over=0.
  - dx=+ (right), dy=+ (down), state SERVE, serve counter 0.
- Reset asserted mid-game returns all of the above immediately.
- FSM states: SERVE, PLAY, SCORED, GAME_OVER. All motion happens only on clk edges with game_tick=1; game_tick is ignored in SCORED and GAME_OVER.
- SERVE:
  - Ball held at centre; counter increments per tick.
  - On the SERVE_TICKS-th tick, clear the counter and go to PLAY.
  - Motion begins on the next tick.
- PLAY, per tick; the X and Y axes are evaluated independently in the same tick:
  - Y, top wall: if dy=- and ball_y<SPEED_Y, set ball_y=0 and dy=+.
  - Y, bottom wall: if dy=+ and ball_y+BALL_SIZE+SPEED_Y>=SCREEN_H, set ball_y=SCREEN_H-BALL_SIZE and dy=-.
  - Y, otherwise: ball_y±=SPEED_Y.
  - Vertical overlap with paddle P is `ball_y+BALL_SIZE>Py` and `ball_y<Py+PADDLE_H`, using pre-move ball_y.
  - X, left paddle hit: dx=-, ball_x>=p1_x+PADDLE_W, ball_x-SPEED_X<=p1_x+PADDLE_W, and overlap with P1. Then ball_x=p1_x+PADDLE_W+1, dx=+.
  - X, right paddle hit: dx=+, ball_x+BALL_SIZE<=p2_x, ball_x+BALL_SIZE+SPEED_X>=p2_x, and overlap with P2. Then ball_x=p2_x-BALL_SIZE-1, dx=-.
  - X, left miss: dx=- and ball_x<SPEED_X. P2 scores; go to SCORED.
  - X, right miss: dx=+ and ball_x+BALL_SIZE+SPEED_X>=SCREEN_W. P1 scores; go to SCORED.
  - X, otherwise: ball_x±=SPEED_X.
  - A paddle hit takes priority over a miss in the same tick.
  - All comparisons use 11-bit unsigned arithmetic, so nothing wraps below 0.
- SCORED (exactly one cycle):
  - Increment the scorer's score, pulse point=1, recentre the ball.
  - Set dx toward the player who conceded; dy is kept.
  - If the new score equals WIN_SCORE, go to GAME_OVER; else go to SERVE.
- GAME_OVER:
  - game_over=1; ball held at centre; scores frozen.
  - restart clears both scores and enters SERVE with dx=+.
  - restart is ignored in all other states.
- Output timing: outputs update one clk after the qualifying game_tick edge. Scores never exceed WIN_SCORE.

Optional Feature:
- Macro: PONG_BALL_SPEEDUP_EN.
- Defined:
  - A 3-bit rally counter increments on each paddle hit, saturating at 7.
  - Horizontal step becomes SPEED_X+rally, with the same collision rules using the effective step.
  - The rally counter clears in SCORED and on reset.
- Undefined: step is fixed at SPEED_X and no rally register exists.

Decomposition:
- Shared package `pong_pkg`:
  - Screen/ball/paddle size constants.
  - FSM state encoding (2-bit: SERVE=0, PLAY=1, SCORED=2, GAME_OVER=3).
  - Coordinate width (10).
- One natural sub-module, `paddle_hit`: combinational overlap and crossing test, instantiated once per paddle.

Test Plan:
- Reset → ball (315,235), scores 0/0, game_over=0. SERVE_TICKS-1=59 ticks → no movement. 60th tick → PLAY. Next tick → ball (319,237).
- Right paddle hit, p2_x=550, p2_y=170 → after 56 PLAY ticks, ball (539,347). Next tick → ball_x=539, dx flips. Following tick → ball_x=535.
- Right miss, p2_y=0 → ball passes the paddle. When ball_x reaches 627, the next tick pulses point, score_p1=1, ball recentres to (315,235), state SERVE, serve toward the right.
- Bottom wall: ball at ball_y=469 with dy=+ → next tick ball_y=470, dy=-. Following tick → 468.
- Game over, WIN_SCORE=2 → two P1 points give game_over=1; further ticks do not move the ball. restart pulse → scores 0/0, SERVE.
- Reset mid-PLAY (rst_b low asynchronously, between edges) → outputs return to reset values immediately, with no clk edge required.
- With PONG_BALL_SPEEDUP_EN: after 3 paddle hits the X step is 7. After a point, the step returns to 4.
